// File: rtl/gray_chk_pkg.sv
// Shared types and constants for the grayscale colour-bar stream checker.
// Optional pixel comparison is enabled by defining GRAY_PIXEL_CHECK_EN.
package gray_chk_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_LINE  = 2'd3
    } chk_state_t;

    localparam int PIX_W_DEF = 10;
    localparam int CNT_W_DEF = 16;

    // All-ones value of a counter of the given width (the saturation ceiling).
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/gray_bar_ref_gen.sv
// Expected-pixel generator for the grayscale bar pattern. Tracks the position
// inside the current bar and the running bar value, so no divider is needed.
// Only instantiated when GRAY_PIXEL_CHECK_EN is defined.
module gray_bar_ref_gen
    import gray_chk_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int BAR_WIDTH = 80,
    parameter int BAR_STEP  = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_line_start,
    input  logic             i_pix_adv,
    output logic [PIX_W-1:0] o_exp
);

    localparam int               POS_W    = $clog2(BAR_WIDTH + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BAR_WIDTH - 1);
    localparam logic [PIX_W-1:0] STEP     = PIX_W'(BAR_STEP);

    logic [POS_W-1:0] r_pos;
    logic [PIX_W-1:0] r_val;
    logic [POS_W-1:0] w_pos_cur;
    logic [PIX_W-1:0] w_val_cur;

    // A line-start pixel is always the first pixel of bar 0.
    assign w_pos_cur = i_line_start ? '0 : r_pos;
    assign w_val_cur = i_line_start ? '0 : r_val;
    assign o_exp     = w_val_cur;

    // Step through the bar; roll to the next bar value after BAR_WIDTH pixels.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pos <= '0;
            r_val <= '0;
        end else if (i_pix_adv) begin
            if (w_pos_cur == POS_LAST) begin
                r_pos <= '0;
                r_val <= w_val_cur + STEP;
            end else begin
                r_pos <= w_pos_cur + POS_W'(1);
                r_val <= w_val_cur;
            end
        end
    end

endmodule

// File: rtl/gray_bar_stream_checker.sv
// Receive-side monitor for the grayscale colour-bar stream: measures line
// length and lines per frame, reports per-frame pass/fail, lock status and
// saturating error counters. Define GRAY_PIXEL_CHECK_EN to also compare every
// active pixel against the expected bar value.
module gray_bar_stream_checker
    import gray_chk_pkg::*;
#(
    parameter int PIX_W       = PIX_W_DEF,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BAR_WIDTH   = 80,
    parameter int BAR_STEP    = 128,
    parameter int LOCK_FRAMES = 4,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             line_valid,
    input  logic             frame_valid,
    input  logic             err_clr,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             locked,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] line_count,
    output logic [CNT_W-1:0] timing_err_cnt,
    output logic [CNT_W-1:0] pixel_err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP    = CNT_W'(V_ACTIVE);
    localparam int               RUN_W    = $clog2(LOCK_FRAMES + 1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return (a == CNT_MAX) ? a : a + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return (s > {1'b0, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    chk_state_t       r_state, w_state_nxt;
    logic             r_lv_s1, r_fv_s1, r_s1_live;
    logic [CNT_W-1:0] r_col, r_lines, w_lines_new;
    logic             r_bad, r_pend_bad, w_bad_new, w_ok_new;
    logic [RUN_W-1:0] r_run, w_run_inc;
    logic [CNT_W-1:0] r_terr;
    logic             w_frame_start, w_frame_end, w_line_start, w_pix_adv, w_close_line;
    logic             w_proto_err, w_line_bad, w_pix_bad;

    // Register the stream once; r_s1_live marks that S1 holds a real sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lv_s1   <= 1'b0;
            r_fv_s1   <= 1'b0;
            r_s1_live <= 1'b0;
        end else begin
            r_lv_s1   <= line_valid;
            r_fv_s1   <= frame_valid;
            r_s1_live <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_SYNC;
        else          r_state <= w_state_nxt;
    end

    // Next state and per-cycle strobes. Edges are implied by the state:
    // FRAME means lv was low, LINE means lv was high, FRAME/LINE mean fv was high.
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_line_start  = 1'b0;
        w_pix_adv     = 1'b0;
        w_close_line  = 1'b0;
        case (r_state)
            ST_SYNC: if (r_s1_live && !r_fv_s1) w_state_nxt = ST_IDLE;
            ST_IDLE: if (r_fv_s1) begin
                w_frame_start = 1'b1;
                if (r_lv_s1) begin
                    w_state_nxt  = ST_LINE;
                    w_line_start = 1'b1;
                    w_pix_adv    = 1'b1;
                end else begin
                    w_state_nxt  = ST_FRAME;
                end
            end
            ST_FRAME: if (!r_fv_s1) begin
                w_frame_end = 1'b1;
                w_state_nxt = ST_IDLE;
            end else if (r_lv_s1) begin
                w_state_nxt  = ST_LINE;
                w_line_start = 1'b1;
                w_pix_adv    = 1'b1;
            end
            ST_LINE: if (!r_fv_s1) begin
                w_close_line = 1'b1;
                w_frame_end  = 1'b1;
                w_state_nxt  = ST_IDLE;
            end else if (!r_lv_s1) begin
                w_close_line = 1'b1;
                w_state_nxt  = ST_FRAME;
            end else begin
                w_pix_adv = 1'b1;
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    assign w_proto_err = r_lv_s1 && !r_fv_s1;
    assign w_line_bad  = w_close_line && (r_col != H_EXP);
    assign w_lines_new = w_close_line ? sat_inc(r_lines) : r_lines;
    assign w_bad_new   = (w_frame_start ? r_pend_bad : r_bad) | w_line_bad | w_pix_bad;
    assign w_ok_new    = !w_bad_new && (w_lines_new == V_EXP);
    assign w_run_inc   = (r_run == RUN_FULL) ? r_run : r_run + RUN_W'(1);

`ifdef GRAY_PIXEL_CHECK_EN
    logic [PIX_W-1:0] r_pix_s1;
    logic [PIX_W-1:0] w_exp;
    logic [CNT_W-1:0] r_perr;

    gray_bar_ref_gen #(
        .PIX_W     (PIX_W),
        .BAR_WIDTH (BAR_WIDTH),
        .BAR_STEP  (BAR_STEP)
    ) u_ref (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_line_start (w_line_start),
        .i_pix_adv    (w_pix_adv),
        .o_exp        (w_exp)
    );

    assign w_pix_bad     = w_pix_adv && (r_pix_s1 != w_exp);
    assign pixel_err_cnt = r_perr;

    // Pixel input stage and saturating mismatch counter (clear wins).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pix_s1 <= '0;
            r_perr   <= '0;
        end else begin
            r_pix_s1 <= pixel_in;
            r_perr   <= err_clr ? '0 : sat_add(r_perr, {1'b0, w_pix_bad});
        end
    end
`else
    logic w_unused_pix;
    assign w_unused_pix  = ^pixel_in;
    assign w_pix_bad     = 1'b0;
    assign pixel_err_cnt = '0;
`endif

    // Column counter: restarts at 1 on the first pixel of a line.
    always_ff @(posedge clk) begin
        if (!reset_n)          r_col <= '0;
        else if (w_line_start) r_col <= CNT_W'(1);
        else if (w_pix_adv)    r_col <= sat_inc(r_col);
    end

    // Per-frame line count and bad flag; protocol errors in IDLE taint the next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lines    <= '0;
            r_bad      <= 1'b0;
            r_pend_bad <= 1'b0;
        end else begin
            r_lines <= w_frame_start ? '0 : w_lines_new;
            r_bad   <= w_bad_new;
            if (w_frame_start)                          r_pend_bad <= 1'b0;
            else if (r_state == ST_IDLE && w_proto_err) r_pend_bad <= 1'b1;
        end
    end

    // Frame results, measurements and lock tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            locked     <= 1'b0;
            line_len   <= '0;
            line_count <= '0;
            r_run      <= '0;
        end else begin
            frame_done <= w_frame_end;
            if (w_close_line) line_len <= r_col;
            if (w_frame_end) begin
                line_count <= w_lines_new;
                frame_ok   <= w_ok_new;
                if (w_ok_new) begin
                    r_run  <= w_run_inc;
                    locked <= (w_run_inc == RUN_FULL);
                end else begin
                    r_run  <= '0;
                    locked <= 1'b0;
                end
            end
        end
    end

    // Saturating timing error counter: bad lines plus protocol cycles (clear wins).
    always_ff @(posedge clk) begin
        if (!reset_n)     r_terr <= '0;
        else if (err_clr) r_terr <= '0;
        else              r_terr <= sat_add(r_terr, {1'b0, w_line_bad} + {1'b0, w_proto_err});
    end

    assign timing_err_cnt = r_terr;

endmodule

// File: tb/tb_gray_bar_stream_checker.sv
// Scoreboard bench for gray_bar_stream_checker (small geometry: 8x4, bars of 2).
module tb_gray_bar_stream_checker;

    localparam int PIX_W = 10;
    localparam int CNT_W = 16;
    localparam int H_A   = 8;
    localparam int V_A   = 4;
    localparam int LOCKN = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [PIX_W-1:0] pixel_in;
    logic             line_valid, frame_valid, err_clr;
    logic             frame_done, frame_ok, locked;
    logic [CNT_W-1:0] line_len, line_count, timing_err_cnt, pixel_err_cnt;

    gray_bar_stream_checker #(
        .PIX_W(PIX_W), .H_ACTIVE(H_A), .V_ACTIVE(V_A), .BAR_WIDTH(2),
        .BAR_STEP(256), .LOCK_FRAMES(LOCKN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in),
        .line_valid(line_valid), .frame_valid(frame_valid), .err_clr(err_clr),
        .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .line_len(line_len), .line_count(line_count),
        .timing_err_cnt(timing_err_cnt), .pixel_err_cnt(pixel_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ok;
        int   lcount;
        int   llen;
        logic lck;
        int   terr;
        int   perr;
        int   cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_done  = 0;
    int   cyc     = 0;

    // bench-side reference model state
    int   m_terr = 0;
    int   m_perr = 0;
    int   m_run  = 0;
    bit   m_pend_bad = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix_val(input int col);
        return PIX_W'(((col - 1) / 2) * 256);
    endfunction

    // Monitor: every frame_done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && frame_done) begin
            n_done++;
            if (sbq.size() == 0) begin
                chk("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("frame_ok",       frame_ok,       mon_e.ok);
                chk("line_count",     line_count,     mon_e.lcount);
                chk("line_len",       line_len,       mon_e.llen);
                chk("locked",         locked,         mon_e.lck);
                chk("timing_err_cnt", timing_err_cnt, mon_e.terr);
                chk("pixel_err_cnt",  pixel_err_cnt,  mon_e.perr);
                chk("done_latency",   cyc,            mon_e.cyc);
            end
        end
    end

    // One 4-line frame. short_line gets short_len pixels; bad_col of bad_line is
    // forced to 0; cut drops fv together with lv at the end of the last line.
    task automatic run_frame(input int short_line, input int short_len,
                             input int bad_line, input int bad_col, input bit cut);
        exp_t e;
        int   len;
        int   last_len;
        bit   bad;
        bad = m_pend_bad;
        m_pend_bad = 1'b0;
        last_len = H_A;
        frame_valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int ln = 0; ln < V_A; ln++) begin
            len = (ln == short_line) ? short_len : H_A;
            last_len = len;
            if (len != H_A) begin
                bad = 1'b1;
                m_terr++;
            end
            for (int c = 1; c <= len; c++) begin
                line_valid = 1'b1;
                pixel_in   = pix_val(c);
                if (ln == bad_line && c == bad_col) begin
                    pixel_in = '0;
`ifdef GRAY_PIXEL_CHECK_EN
                    if (pix_val(c) != '0) begin
                        bad = 1'b1;
                        m_perr++;
                    end
`endif
                end
                @(negedge clk);
            end
            line_valid = 1'b0;
            pixel_in   = '0;
            if (!(cut && ln == V_A - 1)) repeat (2) @(negedge clk);
        end
        frame_valid = 1'b0;
        if (!bad) m_run = (m_run < LOCKN) ? m_run + 1 : m_run;
        else      m_run = 0;
        e.ok = !bad; e.lcount = V_A; e.llen = last_len; e.lck = (m_run == LOCKN);
        e.terr = m_terr; e.perr = m_perr; e.cyc = cyc + 2;
        sbq.push_back(e);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int base;
        reset_n = 1'b0; pixel_in = '0; line_valid = 1'b0; frame_valid = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_ok",   frame_ok,   1'b0);
        chk("rst_locked",     locked,     1'b0);
        chk("rst_line_len",   line_len,   0);
        chk("rst_line_count", line_count, 0);
        chk("rst_terr",       timing_err_cnt, 0);
        chk("rst_perr",       pixel_err_cnt,  0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // four clean frames, lock after the second
        repeat (4) run_frame(-1, 0, -1, 0, 1'b0);
        // short line: timing error, lock lost, then re-lock
        run_frame(1, 7, -1, 0, 1'b0);
        repeat (2) run_frame(-1, 0, -1, 0, 1'b0);
        // pixel 5 of line 1 forced to zero
        run_frame(-1, 0, 1, 5, 1'b0);
        // frame cut while last line open after 5 pixels
        run_frame(3, 5, -1, 0, 1'b1);

        // protocol errors: lv high with fv low, in IDLE
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_terr = 0; m_perr = 0;
        chk("clr_terr", timing_err_cnt, 0);
        chk("clr_perr", pixel_err_cnt,  0);
        line_valid = 1'b1;
        repeat (3) @(negedge clk);
        line_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("proto_terr3", timing_err_cnt, 3);
        line_valid = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_beats_inc", timing_err_cnt, 0);
        @(negedge clk);
        chk("clr_hold", timing_err_cnt, 0);
        m_terr = 0;
        m_pend_bad = 1'b1;
        // frame following IDLE protocol errors is reported bad
        run_frame(-1, 0, -1, 0, 1'b0);

        // reset in mid-frame, released while fv is still high
        frame_valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 1; c <= H_A; c++) begin
            line_valid = 1'b1; pixel_in = pix_val(c);
            @(negedge clk);
        end
        line_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        m_terr = 0; m_perr = 0; m_run = 0; m_pend_bad = 1'b0;
        chk("midrst_line_len", line_len,   0);
        chk("midrst_locked",   locked,     1'b0);
        chk("midrst_terr",     timing_err_cnt, 0);
        reset_n = 1'b1;
        base = n_done;
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 1; c <= H_A; c++) begin
                line_valid = 1'b1; pixel_in = pix_val(c);
                @(negedge clk);
            end
            line_valid = 1'b0; pixel_in = '0;
            repeat (2) @(negedge clk);
        end
        frame_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("partial_no_done", n_done, base);
        run_frame(-1, 0, -1, 0, 1'b0);

        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
